// File: rtl/pll_recfg_seq.sv
// PLL reconfiguration sequencer: drives the eight-register management write
// sequence, pulses the PLL reset and waits for a stable lock.
module pll_recfg_seq #(
    parameter int GAP          = 2,
    parameter int RST_CYCLES   = 4,
    parameter int LOCK_STABLE  = 16,
    parameter int LOCK_TIMEOUT = 1000000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [31:0] m_val,
    input  logic [31:0] k_val,
    input  logic [31:0] c0_val,
    output logic        busy,
    output logic        done,
    output logic        error,
    output logic [5:0]  mgmt_address,
    output logic [31:0] mgmt_writedata,
    output logic        mgmt_write,
    input  logic        mgmt_waitrequest,
    output logic        pll_reset,
    input  logic        locked
);

    localparam int CNT_W = $clog2(GAP + RST_CYCLES + 2);
    localparam int STB_W = $clog2(LOCK_STABLE + 2);
    localparam int TMO_W = $clog2(LOCK_TIMEOUT + 2);

    typedef enum logic [2:0] {
        S_IDLE, S_WRITE, S_GAP, S_PLLRST, S_WAITLOCK, S_FIN
    } state_t;

    // Register-write table: {address, data} for each write index.
    function automatic logic [37:0] write_entry(input logic [2:0] idx, input logic [31:0] m,
                                                input logic [31:0] k, input logic [31:0] c0);
        logic [37:0] e;
        case (idx)
            3'd0:    e = {6'd0, 32'd0};
            3'd1:    e = {6'd4, m};
            3'd2:    e = {6'd7, k};
            3'd3:    e = {6'd3, 32'h0001_0000};
            3'd4:    e = {6'd5, c0};
            3'd5:    e = {6'd9, 32'd1};
            3'd6:    e = {6'd8, 32'd7};
            default: e = {6'd2, 32'd0};
        endcase
        return e;
    endfunction

    state_t            state_q, state_d;
    logic [2:0]        wi_q, wi_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [STB_W-1:0]  stb_q, stb_d;
    logic [TMO_W-1:0]  tmo_q, tmo_d;
    logic [31:0]       m_q, m_d, k_q, k_d, c0_q, c0_d;
    logic              pend_q, pend_d;
    logic [31:0]       pm_q, pm_d, pk_q, pk_d, pc0_q, pc0_d;
    logic              busy_q, busy_d, done_q, done_d, error_q, error_d;
    logic              wr_q, wr_d, prst_q, prst_d;
    logic [5:0]        addr_q, addr_d;
    logic [31:0]       data_q, data_d;
    logic              locked_meta_q, locked_s_q;

    logic              advance, launch;
    logic [31:0]       lm, lk, lc0;

    assign busy           = busy_q;
    assign done           = done_q;
    assign error          = error_q;
    assign mgmt_write     = wr_q;
    assign mgmt_address   = addr_q;
    assign mgmt_writedata = data_q;
    assign pll_reset      = prst_q;

    always_comb begin
        state_d = state_q;
        wi_d    = wi_q;
        cnt_d   = cnt_q;
        stb_d   = stb_q;
        tmo_d   = tmo_q;
        m_d     = m_q;
        k_d     = k_q;
        c0_d    = c0_q;
        pend_d  = pend_q;
        pm_d    = pm_q;
        pk_d    = pk_q;
        pc0_d   = pc0_q;
        busy_d  = busy_q;
        done_d  = 1'b0;
        error_d = error_q;
        wr_d    = wr_q;
        prst_d  = prst_q;
        addr_d  = addr_q;
        data_d  = data_q;
        advance = 1'b0;
        launch  = 1'b0;
        lm      = m_val;
        lk      = k_val;
        lc0     = c0_val;

        // Requests arriving mid-sequence are parked; the newest one wins.
        if (start && state_q != S_IDLE) begin
            pend_d = 1'b1;
            pm_d   = m_val;
            pk_d   = k_val;
            pc0_d  = c0_val;
        end

        case (state_q)
            S_IDLE: begin
                launch = start;
            end
            S_WRITE: begin
                if (!mgmt_waitrequest) begin
                    wr_d  = 1'b0;
                    cnt_d = '0;
                    if (GAP == 0) advance = 1'b1;
                    else          state_d = S_GAP;
                end
            end
            S_GAP: begin
                cnt_d = cnt_q + CNT_W'(1);
                if (cnt_q == CNT_W'(GAP - 1)) advance = 1'b1;
            end
            S_PLLRST: begin
                cnt_d = cnt_q + CNT_W'(1);
                if (cnt_q == CNT_W'(RST_CYCLES - 1)) begin
                    prst_d  = 1'b0;
                    stb_d   = '0;
                    tmo_d   = '0;
                    state_d = S_WAITLOCK;
                end
            end
            S_WAITLOCK: begin
                stb_d = locked_s_q ? stb_q + STB_W'(1) : '0;
                tmo_d = tmo_q + TMO_W'(1);
                // Success is tested first so a simultaneous timeout loses.
                if (stb_q >= STB_W'(LOCK_STABLE)) begin
                    done_d  = 1'b1;
                    state_d = S_FIN;
                end else if (tmo_q >= TMO_W'(LOCK_TIMEOUT)) begin
                    done_d  = 1'b1;
                    error_d = 1'b1;
                    state_d = S_FIN;
                end
            end
            S_FIN: begin
                if (start || pend_q) begin
                    launch = 1'b1;
                    if (!start) begin
                        lm  = pm_q;
                        lk  = pk_q;
                        lc0 = pc0_q;
                    end
                end else begin
                    busy_d  = 1'b0;
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase

        if (advance) begin
            if (wi_q != 3'd7) begin
                wi_d             = wi_q + 3'd1;
                wr_d             = 1'b1;
                {addr_d, data_d} = write_entry(wi_q + 3'd1, m_q, k_q, c0_q);
                state_d          = S_WRITE;
            end else begin
                prst_d  = 1'b1;
                cnt_d   = '0;
                state_d = S_PLLRST;
            end
        end

        if (launch) begin
            m_d              = lm;
            k_d              = lk;
            c0_d             = lc0;
            pend_d           = 1'b0;
            error_d          = 1'b0;
            busy_d           = 1'b1;
            wi_d             = 3'd0;
            wr_d             = 1'b1;
            {addr_d, data_d} = write_entry(3'd0, lm, lk, lc0);
            state_d          = S_WRITE;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q       <= S_IDLE;
            wi_q          <= '0;
            cnt_q         <= '0;
            stb_q         <= '0;
            tmo_q         <= '0;
            m_q           <= '0;
            k_q           <= '0;
            c0_q          <= '0;
            pend_q        <= 1'b0;
            pm_q          <= '0;
            pk_q          <= '0;
            pc0_q         <= '0;
            busy_q        <= 1'b0;
            done_q        <= 1'b0;
            error_q       <= 1'b0;
            wr_q          <= 1'b0;
            prst_q        <= 1'b0;
            addr_q        <= '0;
            data_q        <= '0;
            locked_meta_q <= 1'b0;
            locked_s_q    <= 1'b0;
        end else begin
            state_q       <= state_d;
            wi_q          <= wi_d;
            cnt_q         <= cnt_d;
            stb_q         <= stb_d;
            tmo_q         <= tmo_d;
            m_q           <= m_d;
            k_q           <= k_d;
            c0_q          <= c0_d;
            pend_q        <= pend_d;
            pm_q          <= pm_d;
            pk_q          <= pk_d;
            pc0_q         <= pc0_d;
            busy_q        <= busy_d;
            done_q        <= done_d;
            error_q       <= error_d;
            wr_q          <= wr_d;
            prst_q        <= prst_d;
            addr_q        <= addr_d;
            data_q        <= data_d;
            locked_meta_q <= locked;
            locked_s_q    <= locked_meta_q;
        end
    end

endmodule

// File: tb/tb_pll_recfg_seq.sv
// Bench for pll_recfg_seq: predicts the write/reset/lock timeline of each
// request from the sequencing rules and compares every cycle.
module tb_pll_recfg_seq;

    localparam int GAP          = 2;
    localparam int RST_CYCLES   = 4;
    localparam int LOCK_STABLE  = 16;
    localparam int LOCK_TIMEOUT = 100;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        start = 1'b0;
    logic [31:0] m_val = '0, k_val = '0, c0_val = '0;
    logic        mgmt_waitrequest = 1'b0;
    logic        locked = 1'b0;
    logic        busy, done, error, mgmt_write, pll_reset;
    logic [5:0]  mgmt_address;
    logic [31:0] mgmt_writedata;

    int n_total = 0;
    int n_pass  = 0;
    int stall_cfg[8];
    int lk_rl, lk_g, lk_len1;
    bit err_sticky = 1'b0;

    pll_recfg_seq #(
        .GAP(GAP), .RST_CYCLES(RST_CYCLES),
        .LOCK_STABLE(LOCK_STABLE), .LOCK_TIMEOUT(LOCK_TIMEOUT)
    ) dut (
        .clk(clk), .reset(reset), .start(start),
        .m_val(m_val), .k_val(k_val), .c0_val(c0_val),
        .busy(busy), .done(done), .error(error),
        .mgmt_address(mgmt_address), .mgmt_writedata(mgmt_writedata),
        .mgmt_write(mgmt_write), .mgmt_waitrequest(mgmt_waitrequest),
        .pll_reset(pll_reset), .locked(locked)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_total++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    function automatic logic [37:0] exp_write(input int i, input logic [31:0] m,
                                              input logic [31:0] k, input logic [31:0] c0);
        case (i)
            0:       return {6'd0, 32'd0};
            1:       return {6'd4, m};
            2:       return {6'd7, k};
            3:       return {6'd3, 32'h0001_0000};
            4:       return {6'd5, c0};
            5:       return {6'd9, 32'd1};
            6:       return {6'd8, 32'd7};
            default: return {6'd2, 32'd0};
        endcase
    endfunction

    // Cycle k is the interval after clock edge k; the request is sampled at edge 0.
    task automatic run_seq(input bit fresh, input logic [31:0] m, input logic [31:0] k,
                           input logic [31:0] c0, input int next_mode,
                           input logic [31:0] nm, input logic [31:0] nk, input logic [31:0] nc0);
        int s[8];
        int r, f, d_cyc, last, j;
        bit tmo, ew, ep, ed, eb, ee, wq, lv;
        logic [37:0] wd;
        s[0] = 0;
        for (int i = 1; i < 8; i++) s[i] = s[i-1] + 1 + stall_cfg[i-1] + GAP;
        r     = s[7] + 1 + stall_cfg[7] + GAP;
        f     = r + RST_CYCLES;
        tmo   = (lk_rl < 0) || (lk_rl + 2 + LOCK_STABLE > LOCK_TIMEOUT);
        d_cyc = f + (tmo ? LOCK_TIMEOUT + 1 : lk_rl + 2 + LOCK_STABLE + 1);
        last  = (next_mode == 0) ? d_cyc + 1 : d_cyc;

        if (fresh) begin
            @(negedge clk);
            chk("idle_state", 64'({busy, error, mgmt_write}), 64'({1'b0, err_sticky, 1'b0}));
            start  = 1'b1;
            m_val  = m;
            k_val  = k;
            c0_val = c0;
            locked = 1'b0;
        end

        for (int c = 0; c <= last; c++) begin
            @(negedge clk);
            ew = 1'b0;
            wd = '0;
            for (int i = 0; i < 8; i++)
                if (c >= s[i] && c <= s[i] + stall_cfg[i]) begin
                    ew = 1'b1;
                    wd = exp_write(i, m, k, c0);
                end
            ep = (c >= r) && (c < r + RST_CYCLES);
            ed = (c == d_cyc);
            eb = (c <= d_cyc);
            ee = (c >= d_cyc) && tmo;
            chk($sformatf("ctl c%0d {wr,prst,done,busy,err}", c),
                64'({mgmt_write, pll_reset, done, busy, error}), 64'({ew, ep, ed, eb, ee}));
            if (ew) chk($sformatf("wdata c%0d", c), 64'({mgmt_address, mgmt_writedata}), 64'(wd));

            wq = 1'($urandom_range(0, 1));
            for (int i = 0; i < 8; i++) begin
                if (c >= s[i] && c < s[i] + stall_cfg[i]) wq = 1'b1;
                if (c == s[i] + stall_cfg[i]) wq = 1'b0;
            end
            mgmt_waitrequest = wq;

            j  = c - f;
            lv = 1'b0;
            if (j >= 0 && lk_len1 > 0 && j >= lk_g && j < lk_g + lk_len1) lv = 1'b1;
            if (j >= 0 && lk_rl >= 0 && j >= lk_rl) lv = 1'b1;
            if (c >= d_cyc) lv = 1'b0;
            locked = lv;

            start  = 1'b0;
            m_val  = $urandom;
            k_val  = $urandom;
            c0_val = $urandom;
            if ((next_mode == 1 && c == f + 1) || (next_mode == 2 && c == d_cyc)) start = 1'b1;
            if ((next_mode == 1 && c == f + 3) || (next_mode == 2 && c == d_cyc)) begin
                m_val  = nm;
                k_val  = nk;
                c0_val = nc0;
            end
            if (next_mode == 1 && c == f + 3) start = 1'b1;
        end
        err_sticky = tmo;
    endtask

    task automatic set_lock(input int rl, input int g, input int len1);
        lk_rl   = rl;
        lk_g    = g;
        lk_len1 = len1;
    endtask

    task automatic no_stall();
        for (int i = 0; i < 8; i++) stall_cfg[i] = 0;
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: bench did not finish");
        $fatal(1);
    end

    initial begin
        logic [31:0] cm, ck, cc, nm, nk, nc;
        bit fr;
        int mode, g, l1;

        #2 reset = 1'b1;
        repeat (3) @(negedge clk);
        chk("reset_outs", 64'({busy, done, error, mgmt_write, pll_reset, mgmt_address, mgmt_writedata}), 64'd0);
        reset = 1'b0;
        @(negedge clk);
        chk("post_reset_outs", 64'({busy, done, error, mgmt_write, pll_reset}), 64'd0);

        // zero-stall run, locked 10 cycles after reset falls
        no_stall();
        set_lock(10, 0, 0);
        run_seq(1, 32'h404, 32'hA3D7_09E8, 32'h2_0201, 0, 0, 0, 0);

        // K write stalled 3 cycles
        stall_cfg[2] = 3;
        run_seq(1, 32'h404, 32'hA3D7_09E8, 32'h2_0201, 0, 0, 0, 0);
        no_stall();

        // lock never comes
        set_lock(-1, 0, 0);
        run_seq(1, $urandom, $urandom, $urandom, 0, 0, 0, 0);

        // lock glitch: high 10, low 1, high
        set_lock(3 + 10 + 1, 3, 10);
        run_seq(1, $urandom, $urandom, $urandom, 0, 0, 0, 0);

        // stable count and timeout land together: success
        set_lock(LOCK_TIMEOUT - 2 - LOCK_STABLE, 0, 0);
        run_seq(1, $urandom, $urandom, $urandom, 0, 0, 0, 0);
        // one cycle later: timeout
        set_lock(LOCK_TIMEOUT - 1 - LOCK_STABLE, 0, 0);
        run_seq(1, $urandom, $urandom, $urandom, 0, 0, 0, 0);

        // back-to-back: pending request during WAITLOCK, then one in the FIN cycle
        set_lock(10, 0, 0);
        run_seq(1, 32'h404, 32'hA3D7_09E8, 32'h2_0201, 1, 32'h505, 32'hA3D7_09E8, 32'h2_0201);
        set_lock(5, 0, 0);
        run_seq(0, 32'h505, 32'hA3D7_09E8, 32'h2_0201, 2, 32'h606, 32'h1234_5678, 32'h3_0302);
        set_lock(-1, 0, 0);
        run_seq(0, 32'h606, 32'h1234_5678, 32'h3_0302, 2, 32'h707, 32'h1, 32'h2);
        set_lock(0, 0, 0);
        run_seq(0, 32'h707, 32'h1, 32'h2, 0, 0, 0, 0);

        // randomized requests
        fr = 1'b1;
        cm = $urandom; ck = $urandom; cc = $urandom;
        for (int it = 0; it < 10; it++) begin
            for (int i = 0; i < 8; i++)
                stall_cfg[i] = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 3)) : 0;
            case ($urandom_range(0, 3))
                0, 1: set_lock(int'($urandom_range(0, 90)), 0, 0);
                2: begin
                    g  = int'($urandom_range(0, 5));
                    l1 = int'($urandom_range(1, 14));
                    set_lock(g + l1 + int'($urandom_range(1, 3)), g, l1);
                end
                default: set_lock(-1, 0, 0);
            endcase
            mode = (it == 9) ? 0 : int'($urandom_range(0, 2));
            nm = $urandom; nk = $urandom; nc = $urandom;
            run_seq(fr, cm, ck, cc, mode, nm, nk, nc);
            fr = (mode == 0);
            cm = nm; ck = nk; cc = nc;
        end

        // async reset during a stalled write with a request pending
        @(negedge clk);
        start = 1'b1;
        m_val = 32'hDEAD;
        mgmt_waitrequest = 1'b1;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (2) @(negedge clk);
        chk("stalled_before_reset", 64'({busy, mgmt_write}), 64'({1'b1, 1'b1}));
        @(posedge clk);
        #3 reset = 1'b1;
        #1 chk("async_reset_outs", 64'({busy, mgmt_write, pll_reset}), 64'd0);
        @(negedge clk);
        reset = 1'b0;
        mgmt_waitrequest = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk($sformatf("after_reset_idle %0d", i), 64'({busy, mgmt_write, done, error}), 64'd0);
        end
        err_sticky = 1'b0;
        no_stall();
        set_lock(2, 0, 0);
        run_seq(1, $urandom, $urandom, $urandom, 0, 0, 0, 0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
